// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_pkg
// Description : Shared opcode/funct constants, sequencer state encoding and
//               instruction class encoding for the next-PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_JALR   = 6'b001001;

  // REGIMM rt-field selectors (instr[20:16])
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    TGT  = 2'd2,
    FIN  = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    SEQ  = 4'd0,
    BEQ  = 4'd1,
    BNE  = 4'd2,
    BGEZ = 4'd3,
    BLTZ = 4'd4,
    J    = 4'd5,
    JAL  = 4'd6,
    JR   = 4'd7,
    JALR = 4'd8
  } cls_e;

endpackage : npc_pkg
`default_nettype wire

// File: rtl/npc_decode.sv
`default_nettype none
// ============================================================================
// Module      : npc_decode
// Description : Combinational control-transfer classifier. Maps opcode,
//               funct and rt fields to an instruction class and selects the
//               immediate extension mode.
// Ports       : op_i       - instr[31:26]
//               rt_i       - instr[20:16]
//               funct_i    - instr[5:0]
//               cls_o      - class code (cls_e encoding)
//               ext_sign_o - 1: sign-extend immediate, 0: zero-extend
// Revision    : 1.0 - initial release
// ============================================================================
module npc_decode
  import npc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [4:0] rt_i,
  input  logic [5:0] funct_i,
  output logic [3:0] cls_o,
  output logic       ext_sign_o
);

  always_comb begin
    cls_o = SEQ;
    case (op_i)
      OP_BEQ: cls_o = BEQ;
      OP_BNE: cls_o = BNE;
      OP_J:   cls_o = J;
      OP_JAL: cls_o = JAL;
      OP_REGIMM: begin
        if (rt_i == RT_BGEZ)      cls_o = BGEZ;
        else if (rt_i == RT_BLTZ) cls_o = BLTZ;
      end
      OP_RTYPE: begin
        if (funct_i == FN_JR)        cls_o = JR;
        else if (funct_i == FN_JALR) cls_o = JALR;
      end
      default: cls_o = SEQ;
    endcase
  end

  // Logical immediates and lui take a zero-extended field; everything else,
  // branches included, is sign-extended.
  always_comb begin
    ext_sign_o = 1'b1;
    case (op_i)
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: ext_sign_o = 1'b0;
      default:                          ext_sign_o = 1'b1;
    endcase
  end

endmodule : npc_decode
`default_nettype wire

// File: rtl/npc_seq.sv
`default_nettype none
// ============================================================================
// Module      : npc_seq
// Description : Multicycle next-PC and immediate sequencer. Accepts one
//               instruction per start/done handshake, classifies it, extends
//               its immediate, computes branch/jump targets and returns the
//               next PC with taken/link flags.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               start              - request, accepted only when busy=0
//               instr/pc/rs_val/rt_val - operands, sampled on accept
//               busy               - high from the cycle after accept
//                                    through the done cycle
//               done               - one-cycle result-valid pulse
//               npc/imm_ext/taken/link - results, held until next done
// Revision    : 1.0 - initial release
// ============================================================================
module npc_seq
  import npc_pkg::*;
#(
  parameter int PC_INC = 4,
  parameter int IMM_W  = 16,
  parameter int IDX_W  = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] npc,
  output logic [31:0] imm_ext,
  output logic        taken,
  output logic        link
);

  state_e      state_q;
  logic [31:0] instr_q, pc_q, rs_q, rt_q;
  cls_e        cls_q;
  logic        ext_sign_q;
  logic [31:0] imm_q;
  logic [31:0] pc4_q, btgt_q, jtgt_q;
  logic        cond_q;
  logic        busy_q, done_q, taken_q, link_q;
  logic [31:0] npc_q, imm_ext_q;

  logic [3:0]       w_cls;
  logic             w_ext_sign;
  logic [IMM_W-1:0] w_imm;
  logic [31:0]      imm_d;
  logic [31:0]      pc4_d, boff_d, btgt_d, jtgt_d;
  logic             cond_d;
  logic [31:0]      npc_d;

  npc_decode u_decode (
    .op_i       (instr_q[31:26]),
    .rt_i       (instr_q[20:16]),
    .funct_i    (instr_q[5:0]),
    .cls_o      (w_cls),
    .ext_sign_o (w_ext_sign)
  );

  // Immediate extension and target arithmetic
  assign w_imm  = instr_q[IMM_W-1:0];
  assign imm_d  = w_ext_sign ? {{(32-IMM_W){w_imm[IMM_W-1]}}, w_imm}
                             : {{(32-IMM_W){1'b0}}, w_imm};
  assign pc4_d  = pc_q + 32'(PC_INC);
  assign boff_d = {{(32-IMM_W-2){w_imm[IMM_W-1]}}, w_imm, 2'b00};
  assign btgt_d = pc4_d + boff_d;
  assign jtgt_d = {pc4_d[31:28], instr_q[IDX_W-1:0], 2'b00};

  always_comb begin
    cond_d = 1'b0;
    case (cls_q)
      BEQ:             cond_d = (rs_q == rt_q);
      BNE:             cond_d = (rs_q != rt_q);
      BGEZ:            cond_d = ~rs_q[31];
      BLTZ:            cond_d = rs_q[31];
      J, JAL, JR, JALR: cond_d = 1'b1;
      default:         cond_d = 1'b0;
    endcase
  end

  always_comb begin
    npc_d = pc4_q;
    case (cls_q)
      BEQ, BNE, BGEZ, BLTZ: npc_d = cond_q ? btgt_q : pc4_q;
      J, JAL:               npc_d = jtgt_q;
      JR, JALR:             npc_d = rs_q;   // low bits pass through as-is
      default:              npc_d = pc4_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      pc_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      cls_q      <= SEQ;
      ext_sign_q <= 1'b0;
      imm_q      <= '0;
      pc4_q      <= '0;
      btgt_q     <= '0;
      jtgt_q     <= '0;
      cond_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      npc_q      <= '0;
      imm_ext_q  <= '0;
      taken_q    <= 1'b0;
      link_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // The done cycle is spent in IDLE with busy still high, so a
          // start there is dropped and busy falls on the following edge.
          done_q <= 1'b0;
          if (start && !busy_q) begin
            instr_q <= instr;
            pc_q    <= pc;
            rs_q    <= rs_val;
            rt_q    <= rt_val;
            busy_q  <= 1'b1;
            state_q <= DEC;
          end else begin
            busy_q <= 1'b0;
          end
        end
        DEC: begin
          cls_q      <= cls_e'(w_cls);
          ext_sign_q <= w_ext_sign;
          imm_q      <= imm_d;
          state_q    <= TGT;
        end
        TGT: begin
          pc4_q   <= pc4_d;
          btgt_q  <= btgt_d;
          jtgt_q  <= jtgt_d;
          cond_q  <= cond_d;
          state_q <= FIN;
        end
        FIN: begin
          done_q    <= 1'b1;
          npc_q     <= npc_d;
          imm_ext_q <= imm_q;
          taken_q   <= cond_q;
          link_q    <= (cls_q == JAL) || (cls_q == JALR);
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign npc     = npc_q;
  assign imm_ext = imm_ext_q;
  assign taken   = taken_q;
  assign link    = link_q;

  // Extension mode is kept for the control FSM's visibility in debug only.
  logic w_unused;
  assign w_unused = ext_sign_q;

endmodule : npc_seq
`default_nettype wire

// File: tb/tb_npc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_seq
// Description : Directed self-checking bench for npc_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] instr, pc, rs_val, rt_val;
  logic        busy, done, taken, link;
  logic [31:0] npc, imm_ext;

  int errors;
  int checks;

  npc_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .instr   (instr),
    .pc      (pc),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .done    (done),
    .npc     (npc),
    .imm_ext (imm_ext),
    .taken   (taken),
    .link    (link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge, then count cycles until done (bounded).
  // lat is the number of edges from accept to the first cycle showing done;
  // -1 means done never appeared.
  task automatic issue(input logic [31:0] i_in, input logic [31:0] p_in,
                       input logic [31:0] rs_in, input logic [31:0] rt_in,
                       output int lat);
    @(negedge clk);
    instr = i_in; pc = p_in; rs_val = rs_in; rt_val = rt_in; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    instr = '0; pc = '0; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, taken, link} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, taken, link});
    end
    checks++;
    if ({npc, imm_ext} !== 64'h0) begin
      errors++; $display("FAIL reset_data got npc=%h imm=%h exp=0", npc, imm_ext);
    end
  endtask

  task automatic test_branch();
    int lat;
    issue(32'h1109FFFF, 32'h00400000, 32'd5, 32'd5, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL beq_latency got=%0d exp=4", lat); end
    checks++;
    if (npc !== 32'h00400000) begin errors++; $display("FAIL beq_t_npc got=%h exp=00400000", npc); end
    checks++;
    if (imm_ext !== 32'hFFFFFFFF) begin errors++; $display("FAIL beq_t_imm got=%h exp=FFFFFFFF", imm_ext); end
    checks++;
    if ({taken, link} !== 2'b10) begin errors++; $display("FAIL beq_t_flags got=%b exp=10", {taken, link}); end
    issue(32'h1109FFFF, 32'h00400000, 32'd5, 32'd6, lat);
    checks++;
    if (npc !== 32'h00400004 || taken !== 1'b0) begin
      errors++; $display("FAIL beq_nt got npc=%h taken=%b exp 00400004/0", npc, taken);
    end
    // bne taken with same unequal operands
    issue(32'h1509FFFF, 32'h00400000, 32'd5, 32'd6, lat);
    checks++;
    if (npc !== 32'h00400000 || taken !== 1'b1) begin
      errors++; $display("FAIL bne_t got npc=%h taken=%b exp 00400000/1", npc, taken);
    end
    // bgez rs=0 -> taken, target 0x1004 + 12
    issue(32'h04010003, 32'h00001000, 32'h0, 32'h0, lat);
    checks++;
    if (npc !== 32'h00001010 || taken !== 1'b1) begin
      errors++; $display("FAIL bgez_t got npc=%h taken=%b exp 00001010/1", npc, taken);
    end
    // bltz rs=0 -> not taken
    issue(32'h04000003, 32'h00001000, 32'h0, 32'h0, lat);
    checks++;
    if (npc !== 32'h00001004 || taken !== 1'b0) begin
      errors++; $display("FAIL bltz_nt got npc=%h taken=%b exp 00001004/0", npc, taken);
    end
    // bltz negative rs -> taken
    issue(32'h04000003, 32'h00001000, 32'h80000000, 32'h0, lat);
    checks++;
    if (npc !== 32'h00001010 || taken !== 1'b1) begin
      errors++; $display("FAIL bltz_t got npc=%h taken=%b exp 00001010/1", npc, taken);
    end
  endtask

  task automatic test_jump();
    int lat;
    issue(32'h08100010, 32'h00400000, 32'h0, 32'h0, lat);
    checks++;
    if ({npc, taken, link} !== {32'h00400040, 2'b10}) begin
      errors++; $display("FAIL j got npc=%h t=%b l=%b exp 00400040/1/0", npc, taken, link);
    end
    issue(32'h0C100010, 32'h00400000, 32'h0, 32'h0, lat);
    checks++;
    if ({npc, taken, link} !== {32'h00400040, 2'b11}) begin
      errors++; $display("FAIL jal got npc=%h t=%b l=%b exp 00400040/1/1", npc, taken, link);
    end
    // j keeps upper nibble of pc+4
    issue(32'h08100010, 32'hA0000000, 32'h0, 32'h0, lat);
    checks++;
    if (npc !== 32'hA0400040) begin errors++; $display("FAIL j_region got=%h exp=A0400040", npc); end
    issue(32'h01000008, 32'h00400000, 32'h10000000, 32'h0, lat);
    checks++;
    if ({npc, taken, link} !== {32'h10000000, 2'b10}) begin
      errors++; $display("FAIL jr got npc=%h t=%b l=%b exp 10000000/1/0", npc, taken, link);
    end
    issue(32'h0100F809, 32'h00400000, 32'h12345679, 32'h0, lat);
    checks++;
    if ({npc, taken, link} !== {32'h12345679, 2'b11}) begin
      errors++; $display("FAIL jalr got npc=%h t=%b l=%b exp 12345679/1/1", npc, taken, link);
    end
    checks++;
    if (imm_ext !== 32'hFFFFF809) begin errors++; $display("FAIL jalr_imm got=%h exp=FFFFF809", imm_ext); end
  endtask

  task automatic test_extension();
    int lat;
    issue(32'h35088000, 32'h00400000, 32'h0, 32'h0, lat);
    checks++;
    if ({imm_ext, npc, taken} !== {32'h00008000, 32'h00400004, 1'b0}) begin
      errors++; $display("FAIL ori got imm=%h npc=%h t=%b exp 00008000/00400004/0", imm_ext, npc, taken);
    end
    issue(32'h21088000, 32'h00400000, 32'h0, 32'h0, lat);
    checks++;
    if (imm_ext !== 32'hFFFF8000) begin errors++; $display("FAIL addi_imm got=%h exp=FFFF8000", imm_ext); end
    issue(32'h3C08FFFF, 32'h00400000, 32'h0, 32'h0, lat);
    checks++;
    if (imm_ext !== 32'h0000FFFF) begin errors++; $display("FAIL lui_imm got=%h exp=0000FFFF", imm_ext); end
  endtask

  task automatic test_wrap();
    int lat;
    issue(32'h21088000, 32'hFFFFFFFC, 32'h0, 32'h0, lat);
    checks++;
    if (npc !== 32'h00000000) begin errors++; $display("FAIL wrap_npc got=%h exp=00000000", npc); end
  endtask

  task automatic test_ignore_busy();
    int ndone;
    logic saw_busy;
    ndone = 0; saw_busy = 1'b0;
    @(negedge clk);
    instr = 32'h08100010; pc = 32'h0; rs_val = '0; rt_val = '0; start = 1'b1;
    // hold start through DEC, TGT, FIN and the done cycle
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0 && busy === 1'b1) saw_busy = 1'b1;
      if (done === 1'b1) ndone++;
      if (k == 1) instr = 32'h0C100020;
    end
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (!saw_busy) begin errors++; $display("FAIL busy_after_accept got=0 exp=1"); end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    checks++;
    if ({npc, link} !== {32'h00400040, 1'b0}) begin
      errors++; $display("FAIL ignore_result got npc=%h l=%b exp 00400040/0", npc, link);
    end
  endtask

  task automatic test_back_to_back();
    int first, second;
    first = -1; second = -1;
    @(negedge clk);
    instr = 32'h21080001; pc = 32'h100; rs_val = '0; rt_val = '0; start = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (first < 0) first = j; else if (second < 0) second = j;
      end
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (first !== 3) begin errors++; $display("FAIL b2b_first got=%0d exp=3", first); end
    checks++;
    if (second !== 8) begin errors++; $display("FAIL b2b_second got=%0d exp=8", second); end
  endtask

  task automatic test_reset_midop();
    int ndone, lat;
    logic bad;
    ndone = 0; bad = 1'b0;
    @(negedge clk);
    instr = 32'h0C100010; pc = 32'h00400000; rs_val = '0; rt_val = '0; start = 1'b1;
    @(negedge clk);            // DEC cycle
    start = 1'b0;
    @(negedge clk);            // TGT cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dut.state_q !== npc_pkg::IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state got st=%0d busy=%b exp 0/0", dut.state_q, busy);
    end
    checks++;
    if ({npc, imm_ext, taken, link, done} !== 67'h0) begin
      errors++; $display("FAIL rst_mid_outs got npc=%h imm=%h t=%b l=%b d=%b exp 0", npc, imm_ext, taken, link, done);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (busy === 1'b1) bad = 1'b1;
    end
    checks++;
    if (ndone !== 0 || bad) begin errors++; $display("FAIL rst_mid_nodone got dones=%0d busy_seen=%b exp 0/0", ndone, bad); end
    issue(32'h0C100010, 32'h00400000, 32'h0, 32'h0, lat);
    checks++;
    if (lat !== 4 || {npc, taken, link} !== {32'h00400040, 2'b11}) begin
      errors++; $display("FAIL rst_mid_after got lat=%0d npc=%h t=%b l=%b exp 4/00400040/1/1", lat, npc, taken, link);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_branch();
    test_jump();
    test_extension();
    test_wrap();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_npc_seq
`default_nettype wire
